apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
APB initiator that turns a simple valid/ready request stream (address, write flag, write data) into single APB transfers. It drives the master side of apb_interface and returns one response per request (read data, error flag) on a valid/ready response channel. The matrix-multiplier control logic and the test harness use it to program and read back APB slaves. One transfer is in flight at a time. A configurable timeout protects against slaves that never assert pready.

Parameters:
ADDR_WIDTH, 32, width of paddr and req_addr
DATA_WIDTH, 32, width of pwdata/prdata/req_wdata/rsp_rdata
TIMEOUT_CYCLES, 256, maximum ACCESS cycles without pready before abort; 0 disables the timeout

Ports:
pclk  input  1  clock
preset_n  input  1  reset, asynchronous assert, active-low
req_valid  input  1  request present
req_ready  output  1  request accepted this cycle when req_valid=1
req_write  input  1  1=write, 0=read
req_addr  input  ADDR_WIDTH  target address
req_wdata  input  DATA_WIDTH  write data, ignored for reads
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed this cycle when rsp_valid=1
rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and on timeout
rsp_err  output  1  1 = transfer aborted by timeout
paddr  output  ADDR_WIDTH  APB address
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
pwdata  output  DATA_WIDTH  APB write data
pready  input  1  APB slave ready
prdata  input  DATA_WIDTH  APB read data

Behaviour:
- Single clock pclk. Reset preset_n is asynchronous and active-low; it is synchronously deasserted upstream.
- Reset values: all outputs 0 (req_ready 0 during reset); FSM in IDLE; timeout counter 0.
- FSM states and per-state outputs:
  - IDLE: req_ready=1, psel=0, penable=0, rsp_valid=0.
  - SETUP: psel=1, penable=0. Always lasts exactly 1 cycle, then ACCESS.
  - ACCESS: psel=1, penable=1.
    - pready=1: capture prdata into rsp_rdata for reads (0 for writes), rsp_err=0, go to RESP.
    - Timeout counter == TIMEOUT_CYCLES-1 and pready=0 (TIMEOUT_CYCLES != 0): go to RESP with rsp_err=1, rsp_rdata=0.
  - RESP: rsp_valid=1, psel=0, penable=0; rsp_rdata/rsp_err held stable until the handshake.
    - rsp_ready=1: complete the response. req_ready=1 in this same cycle.
    - rsp_ready=1 and req_valid=1: accept the new request and go directly to SETUP.
    - rsp_ready=1 and req_valid=0: go to IDLE.
- req_ready = IDLE || (RESP && rsp_ready). It is combinational from state and rsp_ready only, never from req_valid.
- On acceptance, register req_addr/req_write/req_wdata into paddr/pwrite/pwdata. Those outputs hold from SETUP through the end of ACCESS and keep their last value while idle.
- Latency: request accepted in cycle N; SETUP N+1; ACCESS N+2. With pready=1 at N+2, rsp_valid=1 at N+3. Each slave wait state adds 1 cycle.
- Throughput: with rsp_ready tied 1 and req_valid held 1, one transfer per 3 cycles.
- Timeout counter: cleared on entering ACCESS; increments each ACCESS cycle with pready=0; width $clog2(TIMEOUT_CYCLES+1), minimum 1.
- On timeout, psel/penable drop the next cycle. The slave must tolerate the abort; rsp_err flags it.
- pready outside ACCESS is ignored.
- Reset mid-transfer: psel/penable/rsp_valid go to 0 immediately (asynchronous). The pending request and response are discarded; after reset the block is in IDLE.
- rsp_valid, once asserted, stays asserted until rsp_ready=1 (no retraction).

Decomposition:
- Shared package apb_pkg:
  - typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS, APB_RESP} apb_state_t.
  - APB_DEFAULT_ADDR_WIDTH/APB_DEFAULT_DATA_WIDTH constants for use with apb_interface.
- No sub-module: the FSM, request registers and timeout counter sit in one module.
- An interface-port wrapper binding apb_interface.master to the flat APB ports is optional and lives at integration level.

Test Plan:
- Write 0x0000_0010 <- 0xDEADBEEF, pready=1 in first ACCESS -> psel rises at N+1, penable at N+2 with pwrite=1, pwdata=0xDEADBEEF; rsp_valid at N+3, rsp_rdata=0, rsp_err=0.
- Read 0x0000_0020, slave inserts 3 wait states, prdata=0x1234_5678 -> ACCESS lasts 4 cycles with paddr stable; rsp_rdata=0x12345678 at N+6.
- Back-to-back 4 writes, req_valid and rsp_ready held 1 -> psel pulses every 3 cycles, no IDLE cycle between transfers, 4 responses in order.
- Response backpressure: rsp_ready=0 for 5 cycles after read -> rsp_valid and rsp_rdata stable, req_ready=0, psel=0 throughout; completion on rsp_ready=1.
- Timeout with TIMEOUT_CYCLES=8, pready stuck 0 -> exactly 8 ACCESS cycles, then psel=0, rsp_valid=1, rsp_err=1, rsp_rdata=0.
- preset_n pulsed low during ACCESS -> psel/penable/rsp_valid go 0 without waiting for pclk; after release req_ready=1 and the next transfer completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: bridge FSM state type and default bus widths.
package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2,
    APB_RESP   = 2'd3
  } apb_state_t;

  localparam int APB_DEFAULT_ADDR_WIDTH = 32;
  localparam int APB_DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/apb_master_bridge_if.sv
// APB bus bundle with master (initiator) and slave (completer) views.
interface apb_interface
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DEFAULT_DATA_WIDTH
) (
  input logic pclk,
  input logic preset_n
);

  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;

  modport master (
    input  pclk, preset_n,
    output paddr, psel, penable, pwrite, pwdata,
    input  pready, prdata
  );

  modport slave (
    input  pclk, preset_n,
    input  paddr, psel, penable, pwrite, pwdata,
    output pready, prdata
  );

endinterface

// File: rtl/apb_master_bridge.sv
// Request/response stream to APB initiator; one transfer in flight, with an
// optional abort when the slave holds pready low for too long.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  // request channel
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  // APB master side
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TO_ENABLED = (TIMEOUT_CYCLES > 0);

  apb_state_t            state_reg, state_next;
  logic [TW-1:0]         cnt_reg;
  logic [ADDR_WIDTH-1:0] paddr_reg;
  logic                  pwrite_reg;
  logic [DATA_WIDTH-1:0] pwdata_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  err_reg;

  logic accept;
  logic access_done;
  logic timeout_hit;

  // Handshake and termination conditions. req_ready is gated by reset so the
  // upstream never sees a ready while the block is held in reset.
  assign req_ready   = preset_n &&
                       ((state_reg == APB_IDLE) || ((state_reg == APB_RESP) && rsp_ready));
  assign accept      = req_valid && req_ready;
  assign access_done = (state_reg == APB_ACCESS) && pready;
  assign timeout_hit = TO_ENABLED && (state_reg == APB_ACCESS) && !pready && (cnt_reg == TO_LAST);

  // Bus and response outputs decode straight from state, so an asynchronous
  // reset drops psel/penable/rsp_valid without waiting for a clock edge.
  assign psel      = (state_reg == APB_SETUP) || (state_reg == APB_ACCESS);
  assign penable   = (state_reg == APB_ACCESS);
  assign rsp_valid = (state_reg == APB_RESP);
  assign paddr     = paddr_reg;
  assign pwrite    = pwrite_reg;
  assign pwdata    = pwdata_reg;
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

  // Next-state logic; RESP with a new request skips IDLE to keep 3-cycle throughput.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      APB_IDLE:   if (req_valid) state_next = APB_SETUP;
      APB_SETUP:  state_next = APB_ACCESS;
      APB_ACCESS: if (pready || timeout_hit) state_next = APB_RESP;
      APB_RESP:   if (rsp_ready) state_next = req_valid ? APB_SETUP : APB_IDLE;
      default:    state_next = APB_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state_reg <= APB_IDLE;
    else           state_reg <= state_next;
  end

  // Capture the request on acceptance; values persist while idle.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      paddr_reg  <= '0;
      pwrite_reg <= 1'b0;
      pwdata_reg <= '0;
    end else if (accept) begin
      paddr_reg  <= req_addr;
      pwrite_reg <= req_write;
      pwdata_reg <= req_wdata;
    end
  end

  // Wait-state counter: zeroed in SETUP so it starts clean on ACCESS entry.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n)                                  cnt_reg <= '0;
    else if (state_reg == APB_SETUP)                cnt_reg <= '0;
    else if ((state_reg == APB_ACCESS) && !pready)  cnt_reg <= cnt_reg + TW'(1);
  end

  // Response capture; held through RESP until the consumer takes it.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else if (access_done) begin
      rdata_reg <= pwrite_reg ? '0 : prdata;
      err_reg   <= 1'b0;
    end else if (timeout_hit) begin
      rdata_reg <= '0;
      err_reg   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge: transfers are described by their
// slave wait count and response backpressure, and the expected bus timing and
// response are derived from those numbers alone.
module tb_apb_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;  // pready goes high on this ACCESS cycle (0-based)
    int          bp;     // cycles of rsp_ready=0 before accepting the response
    int          gap;    // idle cycles before presenting the request; 0 may chain
  } txn_t;

  logic          clk;
  logic          preset_n;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  txn_t q[$];

  apb_interface #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb_if (.pclk(clk), .preset_n(preset_n));

  apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .pclk      (clk),
    .preset_n  (preset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .paddr     (apb_if.paddr),
    .psel      (apb_if.psel),
    .penable   (apb_if.penable),
    .pwrite    (apb_if.pwrite),
    .pwdata    (apb_if.pwdata),
    .pready    (apb_if.pready),
    .prdata    (apb_if.prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic drive_req(input txn_t t);
    req_valid = 1'b1;
    req_write = t.wr;
    req_addr  = t.addr;
    req_wdata = t.wdata;
  endtask

  // Runs every queued transfer cycle by cycle; inputs change and outputs are
  // sampled on the falling edge, combinational req_ready 1 ns later.
  task automatic run_queue();
    bit chained = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      txn_t t = q[i];
      bit   to_hit   = (t.waits >= TO);
      int   n_access = to_hit ? TO : t.waits + 1;
      logic [31:0] exp_rd  = (to_hit || t.wr) ? 32'h0 : t.rdata;
      logic [31:0] exp_err = to_hit ? 32'h1 : 32'h0;

      if (!chained) begin
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle_rsp_valid", rsp_valid, 0);
        repeat (t.gap) @(negedge clk);
        drive_req(t);
        #1 check("idle_req_ready", req_ready, 1);
      end

      // SETUP
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      check("setup_psel", apb_if.psel, 1);
      check("setup_penable", apb_if.penable, 0);
      check("setup_paddr", apb_if.paddr, t.addr);

      // ACCESS: exactly n_access cycles with stable address/controls
      for (int k = 0; k < n_access; k++) begin
        @(negedge clk);
        check("access_psel", apb_if.psel, 1);
        check("access_penable", apb_if.penable, 1);
        check("access_paddr", apb_if.paddr, t.addr);
        check("access_pwrite", apb_if.pwrite, t.wr);
        if (t.wr) check("access_pwdata", apb_if.pwdata, t.wdata);
        apb_if.pready = (k == t.waits);
        apb_if.prdata = (k == t.waits) ? t.rdata : $urandom;
      end

      // RESP, possibly back-pressured
      @(negedge clk);
      apb_if.pready = 1'b0;
      apb_if.prdata = $urandom;
      for (int j = 0; j < t.bp; j++) begin
        check("bp_rsp_valid", rsp_valid, 1);
        check("bp_rsp_rdata", rsp_rdata, exp_rd);
        check("bp_rsp_err", rsp_err, exp_err);
        check("bp_psel", apb_if.psel, 0);
        rsp_ready = 1'b0;
        #1 check("bp_req_ready", req_ready, 0);
        @(negedge clk);
      end
      check("rsp_valid", rsp_valid, 1);
      check("rsp_rdata", rsp_rdata, exp_rd);
      check("rsp_err", rsp_err, exp_err);
      check("rsp_psel", apb_if.psel, 0);
      check("rsp_penable", apb_if.penable, 0);
      rsp_ready = 1'b1;
      chained = (i + 1 < q.size()) && (q[i+1].gap == 0);
      if (chained) drive_req(q[i+1]);
      #1 check("rsp_req_ready", req_ready, 1);
      $display("txn %0d wr=%0d addr=0x%08h waits=%0d bp=%0d rdata=0x%08h err=%0d",
               i, t.wr, t.addr, t.waits, t.bp, rsp_rdata, rsp_err);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    check("end_idle_rsp_valid", rsp_valid, 0);
  endtask

  function automatic txn_t mk(bit wr, logic [31:0] addr, logic [31:0] wd, logic [31:0] rd,
                              int waits, int bp, int gap);
    txn_t t;
    t.wr = wr; t.addr = addr; t.wdata = wd; t.rdata = rd;
    t.waits = waits; t.bp = bp; t.gap = gap;
    return t;
  endfunction

  initial begin
    preset_n      = 1'b0;
    req_valid     = 1'b0;
    req_write     = 1'b0;
    req_addr      = '0;
    req_wdata     = '0;
    rsp_ready     = 1'b0;
    apb_if.pready = 1'b0;
    apb_if.prdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_req_ready", req_ready, 0);
    check("reset_psel", apb_if.psel, 0);
    check("reset_penable", apb_if.penable, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_paddr", apb_if.paddr, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_rsp_err", rsp_err, 0);
    preset_n = 1'b1;

    // Directed: single write, waited read with backpressure, 4 back-to-back
    // writes, timeout, then random traffic.
    q.push_back(mk(1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, 0, 0));
    q.push_back(mk(0, 32'h0000_0020, 32'h0, 32'h1234_5678, 3, 5, 1));
    for (int i = 0; i < 4; i++)
      q.push_back(mk(1, 32'h100 + 32'(4 * i), $urandom, 32'h0, 0, 0, 0));
    q.push_back(mk(0, 32'h0000_0040, 32'h0, 32'hAAAA_5555, 20, 1, 1));
    for (int i = 0; i < 30; i++)
      q.push_back(mk($urandom_range(0, 1), $urandom, $urandom, $urandom,
                     $urandom_range(0, 9), $urandom_range(0, 3), $urandom_range(0, 2)));
    run_queue();

    // Asynchronous reset in the middle of ACCESS
    @(negedge clk);
    drive_req(mk(0, 32'h0000_0080, 32'h0, 32'h0, 0, 0, 0));
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_penable", apb_if.penable, 1);
    #2 preset_n = 1'b0;
    #1;
    check("async_reset_psel", apb_if.psel, 0);
    check("async_reset_penable", apb_if.penable, 0);
    check("async_reset_rsp_valid", rsp_valid, 0);
    check("async_reset_req_ready", req_ready, 0);
    repeat (2) @(negedge clk);
    preset_n = 1'b1;
    #1 check("post_reset_req_ready", req_ready, 1);
    q.delete();
    q.push_back(mk(0, 32'h0000_0084, 32'h0, 32'hCAFE_F00D, 1, 0, 0));
    run_queue();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
